mult_unit: RTL and testbench
============================

MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand width; hi and lo are each WIDTH bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start_mult  input  1  request to begin a multiply; sampled on clk rising edge.
REQ-005 mult_sign  input  1  1 = signed (mult), 0 = unsigned (multu); sampled with start_mult.
REQ-006 srca  input  WIDTH  multiplicand (rs value); sampled with start_mult.
REQ-007 srcb  input  WIDTH  multiplier (rt value); sampled with start_mult.
REQ-008 busy  output  1  high while a multiply is in progress; the hazard unit stalls mfhi/mflo and a new mult/multu on it.
REQ-009 done  output  1  one-cycle pulse when hi/lo are updated with a new product.
REQ-010 hi  output  WIDTH  upper half of the last completed 2*WIDTH-bit product.
REQ-011 lo  output  WIDTH  lower half of the last completed 2*WIDTH-bit product.

Function
REQ-012 The block SHALL be a radix-2 iterative shift-add multiplier with states IDLE, CALC, FINISH.
REQ-013 IDLE: busy=0; if start_mult=1, latch |srca| and |srcb| (magnitude only when mult_sign=1; raw otherwise), latch neg = mult_sign & (srca[MSB] ^ srcb[MSB]), clear the 2*WIDTH accumulator, load count=WIDTH-1, and go to CALC.
REQ-014 Magnitude of the most-negative value (0x80000000) SHALL be treated as the unsigned value 2^(WIDTH-1), with no overflow.
REQ-015 CALC: each cycle, if the multiplier LSB is 1, add the multiplicand (zero-extended to 2*WIDTH) to the accumulator; shift the multiplicand left by 1 and the multiplier right by 1; when count=0 go to FINISH, else decrement count.
REQ-016 CALC SHALL last exactly WIDTH cycles; all arithmetic SHALL be 2*WIDTH bits wide, unsigned, and carry-free beyond bit 2*WIDTH-1.
REQ-017 FINISH: {hi,lo} <= neg ? two's-complement negation of the accumulator : accumulator; done=1 for this cycle only; return to IDLE.
REQ-018 busy SHALL be 1 in CALC and FINISH, and 0 in IDLE.
REQ-019 Latency: start_mult sampled at edge N yields updated hi/lo and done=1 in the cycle after edge N+WIDTH+1 (N+33 for WIDTH=32).
REQ-020 start_mult asserted while busy=1 SHALL be ignored; the operation in progress is unaffected and no request is queued.
REQ-021 start_mult in the same cycle as the done pulse SHALL be ignored; a new start is accepted only in IDLE.
REQ-022 hi and lo SHALL hold their value between products and SHALL NOT change during CALC; mfhi/mflo during busy reads the previous product.
REQ-023 A zero operand SHALL still take the full WIDTH-cycle latency; there is no early termination.
REQ-024 Operand inputs SHALL be ignored except in the cycle start_mult is accepted.

Reset
REQ-025 While reset=1 at a clock edge: state=IDLE, busy=0, done=0, hi=0, lo=0, accumulator=0, count=0, neg=0.
REQ-026 Reset during CALC or FINISH SHALL abort the operation with no done pulse and hi/lo=0; reset has priority over start_mult.
REQ-027 After reset deasserts, the first start_mult SHALL be accepted in the next cycle.

Verification
REQ-028 Unsigned: start_mult=1, mult_sign=0, srca=0xFFFFFFFF, srcb=0xFFFFFFFF -> after 33 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001; busy=1 for 33 cycles.
REQ-029 Signed: mult_sign=1, srca=0xFFFFFFFE (-2), srcb=0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; then srca=srcb=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-030 Ignore while busy: start 7*6 unsigned, then start_mult=1 with srca=5, srcb=5 at cycle 10 -> single done at cycle 33 with hi=0, lo=0x0000002A; no second done.
REQ-031 Reset mid-op: complete 3*4 (lo=0xC), start 0x10000*0x10000, assert reset at cycle 15 -> busy=0, hi=lo=0, no done pulse; next start 2*2 -> lo=4 after 33 cycles.
REQ-032 Hold/back-to-back: after 9*9 (lo=0x51), start 0*0x12345678 on the cycle after done -> hi/lo stay 0x0/0x51 through CALC, then become 0/0 with done after 33 cycles.

Source files
------------

// File: rtl/mult_unit.sv
// mult_unit: radix-2 iterative shift-add multiplier for mult/multu.
//
// A request is accepted only from IDLE, and not in the cycle the done pulse is
// shown. The block then runs WIDTH shift-add cycles (CALC) and a FINISH cycle
// that applies the sign and writes {hi,lo}. Signed operands are reduced to
// magnitudes up front, so the whole datapath is unsigned, 2*WIDTH bits wide.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset (aborts any operation)
//   start_mult in   begin a multiply (ignored unless idle)
//   mult_sign  in   1 = signed (mult), 0 = unsigned (multu)
//   srca       in   multiplicand (rs)
//   srcb       in   multiplier   (rt)
//   busy       out  high in CALC and FINISH
//   done       out  one-cycle pulse alongside a freshly written {hi,lo}
//   hi, lo     out  upper/lower halves of the last completed product
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             mult_sign,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t               state_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [CW-1:0]        count_q;
  logic                 neg_q;
  logic                 done_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   prod_d;
  logic                 neg_d;
  logic                 accept_d;

  // Magnitude of a possibly-signed operand. For the most-negative value the
  // WIDTH-bit negation wraps back to 1000...0, which read as unsigned is
  // exactly 2^(WIDTH-1), so no extra bit is needed.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             sgn);
    if (sgn && x[WIDTH-1]) begin
      return (~x) + WIDTH'(1);
    end
    return x;
  endfunction

  // Two's-complement negation of the full-width product.
  function automatic logic [2*WIDTH-1:0] negate2w(input logic [2*WIDTH-1:0] x);
    return (~x) + (2*WIDTH)'(1);
  endfunction

  // Result sign only matters for signed requests.
  assign neg_d    = mult_sign & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
  // A start in the done-pulse cycle is deliberately dropped.
  assign accept_d = (state_q == IDLE) && start_mult && !done_q;
  assign acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign prod_d   = neg_q ? negate2w(acc_q) : acc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            mcand_q  <= {{WIDTH{1'b0}}, magnitude(srca, mult_sign)};
            mplier_q <= magnitude(srcb, mult_sign);
            neg_q    <= neg_d;
            acc_q    <= '0;
            count_q  <= CW'(WIDTH - 1);
            state_q  <= CALC;
          end
        end
        CALC: begin
          // One multiplier bit per cycle; always WIDTH cycles, no early exit.
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (count_q == '0) begin
            state_q <= FINISH;
          end else begin
            count_q <= count_q - CW'(1);
          end
        end
        FINISH: begin
          {hi_q, lo_q} <= prod_d;
          done_q       <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
module tb_mult_unit;

  logic        clk;
  logic        reset;
  logic        start_mult;
  logic        mult_sign;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  mult_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .mult_sign  (mult_sign),
    .srca       (srca),
    .srcb       (srcb),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered at a negedge with the unit idle. Starts a multiply, tracks
  // latency, busy cycles and hi/lo stability, checks the result, then drives
  // a start during the done cycle which must be ignored.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input int inject, input string tag);
    logic [31:0] ph, pl;
    int n, bcnt;
    bit hold_ok;
    ph = hi;
    pl = lo;
    start_mult = 1'b1;
    mult_sign  = sgn;
    srca       = a;
    srcb       = b;
    cyc();
    start_mult = 1'b0;
    srca       = $urandom;
    srcb       = $urandom;
    mult_sign  = 1'($urandom);
    bcnt    = busy ? 1 : 0;
    hold_ok = 1'b1;
    n       = 0;
    while (!done && n < 60) begin
      if (inject > 0 && n == inject) begin
        start_mult = 1'b1;
        mult_sign  = 1'b0;
        srca       = 32'd5;
        srcb       = 32'd5;
      end else begin
        start_mult = 1'b0;
      end
      cyc();
      n++;
      if (!done) begin
        if (busy) bcnt++;
        if (hi !== ph || lo !== pl) hold_ok = 1'b0;
      end
    end
    start_mult = 1'b0;
    chk({tag, "_latency"}, 64'(n), 64'd33);
    chk({tag, "_busycycles"}, 64'(bcnt), 64'd33);
    chk({tag, "_hold"}, 64'(hold_ok), 64'd1);
    chk({tag, "_hilo"}, {hi, lo}, {eh, el});
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    // Start coinciding with the done pulse must be dropped.
    start_mult = 1'b1;
    mult_sign  = 1'b0;
    srca       = $urandom;
    srcb       = $urandom;
    cyc();
    start_mult = 1'b0;
    chk({tag, "_done_pulse_width"}, 64'(done), 64'd0);
    chk({tag, "_start_at_done_ignored"}, 64'(busy), 64'd0);
  endtask

  task automatic quiet(input int cycles, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      cyc();
      if (done || busy) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    reset      = 1'b1;
    start_mult = 1'b0;
    mult_sign  = 1'b0;
    srca       = '0;
    srcb       = '0;
    @(negedge clk);
    cyc();
    cyc();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);

    // Start on the very first cycle after reset release.
    reset = 1'b0;
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, "u_ffxff");
    run_op(1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, "s_m2x3");
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, "s_minxmin");
    run_op(1'b1, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 0, "s_minx1");
    run_op(1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 0, "u_minx2");
    run_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 0, "s_7xm1");

    // A second start while busy is neither taken nor queued.
    run_op(1'b0, 32'd7, 32'd6, 32'h0, 32'h0000_002A, 10, "busy_ignore");
    quiet(40, "busy_ignore_no_second_done");

    // Reset in the middle of a multiply.
    run_op(1'b0, 32'd3, 32'd4, 32'h0, 32'h0000_000C, 0, "pre_reset_3x4");
    start_mult = 1'b1;
    mult_sign  = 1'b0;
    srca       = 32'h0001_0000;
    srcb       = 32'h0001_0000;
    cyc();
    start_mult = 1'b0;
    repeat (14) cyc();
    chk("midop_busy_before_reset", 64'(busy), 64'd1);
    reset = 1'b1;
    cyc();
    chk("midop_reset_busy", 64'(busy), 64'd0);
    chk("midop_reset_done", 64'(done), 64'd0);
    chk("midop_reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    run_op(1'b0, 32'd2, 32'd2, 32'h0, 32'h0000_0004, 0, "post_reset_2x2");

    // Back-to-back: the next start lands on the cycle after done.
    run_op(1'b0, 32'd9, 32'd9, 32'h0, 32'h0000_0051, 0, "b2b_9x9");
    run_op(1'b0, 32'd0, 32'h1234_5678, 32'h0, 32'h0, 0, "b2b_0xN");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
